// File: rtl/full_subtractor_df.sv
// 1-bit full subtractor (a - b - bin) with a combinational result and a
// registered copy that is cleared asynchronously by rst.
module full_subtractor_df (
   input  logic clk,
   input  logic rst,
   output logic d,
   output logic bout,
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d_q,
   output logic bout_q,
   output logic valid_q
);

   // Combinational core: independent of clk and rst.
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~a & bin) | (b & bin);

   // valid_q marks that the registers hold a result captured since the last reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_q     <= 1'b0;
         bout_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         d_q     <= d;
         bout_q  <= bout;
         valid_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_full_subtractor_df.sv
// Directed bench for full_subtractor_df: truth-table sweep under reset,
// registered latency, asynchronous reset mid-stream and reset release.
module tb_full_subtractor_df;

   logic clk;
   logic rst;
   logic a, b, bin;
   logic d, bout, d_q, bout_q, valid_q;

   int check_count;
   int pass_count;
   int fail_count;

   // Hand-computed truth table, indexed by {a,b,bin}.
   logic [7:0] tt_d;
   logic [7:0] tt_bout;

   full_subtractor_df dut (
      .clk     (clk),
      .rst     (rst),
      .d       (d),
      .bout    (bout),
      .a       (a),
      .b       (b),
      .bin     (bin),
      .d_q     (d_q),
      .bout_q  (bout_q),
      .valid_q (valid_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      check_count++;
      assert (obs === exp) pass_count++;
      else begin
         fail_count++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      check_count++;
      assert (obs === exp) pass_count++;
      else begin
         fail_count++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] v);
      {a, b, bin} = v;
   endtask

   initial begin
      logic [2:0] v;
      int lhs;
      int rhs;
      check_count = 0;
      pass_count  = 0;
      fail_count  = 0;
      tt_d    = 8'b1001_0110;
      tt_bout = 8'b1000_1110;

      // Reset state.
      rst = 1'b1;
      drive(3'b000);
      #1;
      check_bit("reset d_q", d_q, 1'b0);
      check_bit("reset bout_q", bout_q, 1'b0);
      check_bit("reset valid_q", valid_q, 1'b0);

      // Exhaustive combinational sweep with rst high; identity check alongside.
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         drive(v);
         #1;
         check_bit($sformatf("sweep d %b", v), d, tt_d[v]);
         check_bit($sformatf("sweep bout %b", v), bout, tt_bout[v]);
         check_bit($sformatf("sweep d_q %b", v), d_q, 1'b0);
         check_bit($sformatf("sweep bout_q %b", v), bout_q, 1'b0);
         check_bit($sformatf("sweep valid_q %b", v), valid_q, 1'b0);
         lhs = int'(v[2]) - int'(v[1]) - int'(v[0]);
         rhs = int'(d) - 2 * int'(bout);
         check_int($sformatf("identity %b", v), rhs, lhs);
         #9;
      end
      check_int("identity min (011)", int'(1'b0) - 2 * int'(1'b1), -2);

      // Registered latency.
      @(negedge clk);
      rst = 1'b0;
      drive(3'b011);
      #1;
      check_bit("pre-edge valid_q", valid_q, 1'b0);
      @(posedge clk);
      #1;
      check_bit("lat1 d_q", d_q, 1'b0);
      check_bit("lat1 bout_q", bout_q, 1'b1);
      check_bit("lat1 valid_q", valid_q, 1'b1);
      @(negedge clk);
      drive(3'b100);
      #1;
      check_bit("hold d", d, 1'b1);
      check_bit("hold bout", bout, 1'b0);
      check_bit("hold d_q", d_q, 1'b0);
      check_bit("hold bout_q", bout_q, 1'b1);
      @(posedge clk);
      #1;
      check_bit("lat2 d_q", d_q, 1'b1);
      check_bit("lat2 bout_q", bout_q, 1'b0);

      // Asynchronous reset mid-stream.
      @(negedge clk);
      drive(3'b111);
      @(posedge clk);
      #1;
      check_bit("pre-rst d_q", d_q, 1'b1);
      check_bit("pre-rst bout_q", bout_q, 1'b1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_bit("async d_q", d_q, 1'b0);
      check_bit("async bout_q", bout_q, 1'b0);
      check_bit("async valid_q", valid_q, 1'b0);
      check_bit("async d", d, 1'b1);
      check_bit("async bout", bout, 1'b1);

      // Hold reset across several edges.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check_bit($sformatf("held valid_q %0d", k), valid_q, 1'b0);
         check_bit($sformatf("held d_q %0d", k), d_q, 1'b0);
      end

      // Reset release: first edge loads current result and sets valid_q.
      @(negedge clk);
      rst = 1'b0;
      drive(3'b001);
      #1;
      check_bit("release pre-edge valid_q", valid_q, 1'b0);
      check_bit("release pre-edge d_q", d_q, 1'b0);
      @(posedge clk);
      #1;
      check_bit("release valid_q", valid_q, 1'b1);
      check_bit("release d_q", d_q, 1'b1);
      check_bit("release bout_q", bout_q, 1'b1);
      @(negedge clk);
      drive(3'b010);
      @(posedge clk);
      #1;
      check_bit("post-release d_q", d_q, 1'b1);
      check_bit("post-release bout_q", bout_q, 1'b1);
      @(negedge clk);
      drive(3'b110);
      @(posedge clk);
      #1;
      check_bit("post-release2 d_q", d_q, 1'b0);
      check_bit("post-release2 bout_q", bout_q, 1'b0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
